// File: rtl/jpeg_rl_pkg.sv
// jpeg_rl_pkg: shared types and constants for the JPEG run-length decoder.
// Holds the FSM state enum, block length and the ZRL/EOB/size encodings.
package jpeg_rl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AC,
        S_RUN,
        S_FILL
    } rld_state_t;

    localparam int         BLKLEN   = 64;
    localparam logic [3:0] ZRL_RLEN = 4'd15;
    localparam logic [3:0] EOB_RLEN = 4'd0;
    localparam logic [3:0] EOB_SIZE = 4'd0;
    localparam logic [3:0] MAX_SIZE = 4'd11;

endpackage

// File: rtl/jpeg_amp_decode.sv
// jpeg_amp_decode: (size, amp) -> signed coefficient, purely combinational.
// Ports: i_size category, i_amp additional bits, o_val two's complement value.
module jpeg_amp_decode #(
    parameter int DWIDTH = 12
) (
    input  logic [3:0]        i_size,
    input  logic [DWIDTH-1:0] i_amp,
    output logic [DWIDTH-1:0] o_val
);

    logic [31:0] w_amp;
    logic [31:0] w_mask;
    logic [31:0] w_bits;
    logic        w_msb;

    always_comb begin
        w_amp  = 32'(i_amp);
        w_mask = (32'd1 << i_size) - 32'd1;
        w_bits = w_amp & w_mask;
        w_msb  = w_amp[i_size - 4'd1];
        if (i_size == 4'd0)
            o_val = '0;
        else if (w_msb)
            o_val = DWIDTH'(w_bits);
        else
            // 32-bit wrap then truncate yields the sign-extended negative value
            o_val = DWIDTH'(w_bits - w_mask);
    end

endmodule

// File: rtl/jpeg_rld.sv
// jpeg_rld: expands (rlen,size,amp) symbols into 64-sample zig-zag blocks.
// Ports: clk, rst (async low), ena, den/dcterm/rlen/size/amp in, rdy,
// dout/douten/dgo out, err sticky. Optional checks: JPEG_RLD_ERRCHK_EN.
module jpeg_rld
    import jpeg_rl_pkg::*;
#(
    parameter int DWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              den,
    input  logic              dcterm,
    input  logic [3:0]        rlen,
    input  logic [3:0]        size,
    input  logic [DWIDTH-1:0] amp,
    output logic              rdy,
    output logic [DWIDTH-1:0] dout,
    output logic              douten,
    output logic              dgo,
    output logic              err
);

    localparam int            PW   = $clog2(BLKLEN);
    localparam logic [PW-1:0] LAST = PW'(BLKLEN - 1);

    rld_state_t        r_state;
    logic [PW-1:0]     r_pos;
    logic [3:0]        r_run;
    logic [DWIDTH-1:0] r_val;
    logic [DWIDTH-1:0] r_dout;
    logic              r_douten;
    logic              r_dgo;

    logic [DWIDTH-1:0] w_val;
    logic              w_eob;
    logic              w_last;
    logic [PW-1:0]     w_pos_nx;

    jpeg_amp_decode #(.DWIDTH(DWIDTH)) u_amp (
        .i_size (size),
        .i_amp  (amp),
        .o_val  (w_val)
    );

    assign rdy      = (r_state == S_IDLE) || (r_state == S_AC);
    assign w_eob    = (size == EOB_SIZE) && (rlen == EOB_RLEN);
    assign w_last   = (r_pos == LAST);
    assign w_pos_nx = w_last ? '0 : r_pos + PW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_pos    <= '0;
            r_run    <= '0;
            r_val    <= '0;
            r_dout   <= '0;
            r_douten <= 1'b0;
            r_dgo    <= 1'b0;
        end else if (ena) begin
            r_douten <= 1'b0;
            r_dgo    <= 1'b0;
            unique case (r_state)
                S_IDLE, S_AC: begin
                    if (den && dcterm) begin
                        // DC always opens a fresh block, even mid-block
                        r_dout   <= w_val;
                        r_douten <= 1'b1;
                        r_dgo    <= 1'b1;
                        r_pos    <= PW'(1);
                        r_state  <= S_AC;
                    end else if (den && r_state == S_AC) begin
                        r_douten <= 1'b1;
                        r_pos    <= w_pos_nx;
                        if (w_eob) begin
                            r_dout  <= '0;
                            r_state <= w_last ? S_IDLE : S_FILL;
                        end else if (rlen == 4'd0) begin
                            r_dout  <= w_val;
                            r_state <= w_last ? S_IDLE : S_AC;
                        end else begin
                            // first zero goes out now; rlen-1 zeros then r_val remain
                            r_dout  <= '0;
                            r_run   <= rlen - 4'd1;
                            r_val   <= w_val;
                            r_state <= w_last ? S_IDLE : S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_douten <= 1'b1;
                    r_pos    <= w_pos_nx;
                    if (r_run == 4'd0) begin
                        r_dout  <= r_val;
                        r_state <= w_last ? S_IDLE : S_AC;
                    end else begin
                        r_dout  <= '0;
                        r_run   <= r_run - 4'd1;
                        r_state <= w_last ? S_IDLE : S_RUN;
                    end
                end
                S_FILL: begin
                    r_douten <= 1'b1;
                    r_pos    <= w_pos_nx;
                    r_dout   <= '0;
                    r_state  <= w_last ? S_IDLE : S_FILL;
                end
            endcase
        end
    end

    assign dout   = r_dout;
    assign douten = r_douten;
    assign dgo    = r_dgo;

`ifdef JPEG_RLD_ERRCHK_EN
    logic r_err;
    logic w_ac_sym;
    logic w_err_set;

    assign w_ac_sym = den && !dcterm;

    always_comb begin
        w_err_set = 1'b0;
        if (r_state == S_IDLE && w_ac_sym)
            w_err_set = 1'b1;
        if (r_state == S_AC && den && dcterm)
            w_err_set = 1'b1;
        if (rdy && den && size > MAX_SIZE)
            w_err_set = 1'b1;
        if (r_state == S_AC && w_ac_sym && size == 4'd0
            && rlen != EOB_RLEN && rlen != ZRL_RLEN)
            w_err_set = 1'b1;
        // overrun: samples still pending when pos BLKLEN-1 goes out
        if (r_state == S_AC && w_ac_sym && !w_eob
            && rlen != 4'd0 && w_last)
            w_err_set = 1'b1;
        if (r_state == S_RUN && w_last && r_run != 4'd0)
            w_err_set = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_err <= 1'b0;
        else if (ena && w_err_set)
            r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
